lspc_vram_cpu_port: RTL
=======================

Name: lspc_vram_cpu_port

Overview:
- CPU-side VRAM access port of the LSPC; sits directly upstream of the slow-VRAM cycle stage and of the fast-VRAM cycle stage.
- Holds the CPU-visible registers VRAMADDR, VRAMRW and VRAMMOD.
- Turns CPU register writes into a single write request plus address/data toward the cycle stages.
- Auto-increments the address by the modulo after each access and keeps a prefetched read word for CPU reads.

Parameters:
- MOD_RESET, 16'h0000, VRAMMOD value loaded on reset.
- ADDR_W, 16, VRAM word-address width; MSB selects fast (1) or slow (0) VRAM.

Ports:
- CLK_24M  in  1  master clock; all state updates on its rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- CPU_WR_ADDR  in  1  one-clock strobe: write VRAMADDR.
- CPU_WR_RW  in  1  one-clock strobe: write VRAMRW.
- CPU_WR_MOD  in  1  one-clock strobe: write VRAMMOD.
- CPU_RD_RW  in  1  one-clock strobe: CPU read of VRAMRW completed.
- CPU_DATA_IN  in  16  CPU write data.
- CPU_DATA_OUT  out  16  prefetched VRAM word; reset 0.
- VRAM_ADDR  out  15  word address to the cycle stages; reset 0.
- REG_VRAMADDR_MSB  out  1  address bit 15, selects fast/slow; reset 0.
- VRAM_WRITE  out  16  write data; reset 0.
- nVRAM_WRITE_REQ  out  1  active-low write request; reset 1.
- RD_REQ  out  1  read/prefetch request; reset 0.
- SLOW_ACK  in  1  one-clock pulse: slow stage performed the access.
- FAST_ACK  in  1  one-clock pulse: fast stage performed the access.
- VRAM_LOW_READ  in  16  slow-VRAM read data; valid in the clock of SLOW_ACK.
- VRAM_HIGH_READ  in  16  fast-VRAM read data; valid in the clock of FAST_ACK.
- BUSY  out  1  high while in WR_PEND, INC or RD_PEND; reset 0.

Behaviour:
- Registers:
  - ADDR[15:0], MOD[15:0], WDATA[15:0], RDATA[15:0].
  - Shadow SH_ADDR[15:0] with flag SH_V.
- Outputs: VRAM_ADDR=ADDR[14:0]; REG_VRAMADDR_MSB=ADDR[15]; VRAM_WRITE=WDATA; CPU_DATA_OUT=RDATA.
- ACK is the ack of the selected bank: SLOW_ACK when ADDR[15]=0, FAST_ACK when ADDR[15]=1. The other bank's ack is ignored.
- On reset: all registers 0, MOD=MOD_RESET, state IDLE, SH_V=0.
- FSM states: IDLE, WR_PEND, INC, RD_PEND.
- IDLE:
  - CPU_WR_ADDR: ADDR<=CPU_DATA_IN, go RD_PEND.
  - CPU_WR_RW: WDATA<=CPU_DATA_IN, go WR_PEND.
  - CPU_WR_MOD: MOD<=CPU_DATA_IN, stay in IDLE.
  - CPU_RD_RW: go INC (read auto-increment).
- WR_PEND:
  - nVRAM_WRITE_REQ=0.
  - On ACK, go INC; nVRAM_WRITE_REQ returns to 1 on the next clock.
- INC, exactly one clock:
  - If SH_V=1: ADDR<=SH_ADDR, SH_V<=0.
  - Else: ADDR<=ADDR+MOD, modulo 2^16. Wrap carries into the MSB, so crossing 7FFF->8000 switches bank.
  - Then go RD_PEND.
- RD_PEND:
  - RD_REQ=1.
  - On ACK, RDATA<=read data of the selected bank, go IDLE.
- Latencies:
  - Write: strobe -> request asserted the next clock.
  - Request held until ACK, with no timeout.
  - ADDR updated 1 clock after ACK.
  - RDATA valid 1 clock after the read ACK.
- CPU strobes while BUSY:
  - CPU_WR_RW: WDATA overwritten (last write wins). If in WR_PEND, the request stays asserted with the new data. If in INC/RD_PEND, the prefetch is abandoned and the FSM goes to WR_PEND at the next edge.
  - CPU_WR_ADDR in WR_PEND: SH_ADDR<=data, SH_V<=1, applied in INC in place of the increment.
  - CPU_WR_ADDR in INC/RD_PEND: ADDR loaded immediately, SH_V<=0, RD_PEND restarts with the new address.
  - CPU_WR_MOD: always takes effect immediately. An INC in the same clock uses the old MOD.
  - CPU_RD_RW while BUSY: ignored.
- Same-clock strobe priority: WR_ADDR > WR_RW > RD_RW. WR_MOD is independent.
- ACK arriving in the same clock as a CPU_WR_RW in WR_PEND: the current access completes and the new data is queued for the next WR_PEND. This goes through INC and then directly to WR_PEND, skipping the prefetch.
- An ACK in IDLE or INC is ignored.
- nRESET asserted mid-operation: immediate return to reset values; any pending request is dropped.

Decomposition:
- Shared package lspc_pkg holds:
  - State enum: IDLE=2'd0, WR_PEND=2'd1, INC=2'd2, RD_PEND=2'd3.
  - VRAM_ADDR_W=16.
  - FAST_BANK_BIT=15.
- One sub-module is natural: lspc_vram_addr_gen. It contains ADDR, SH_ADDR/SH_V, MOD and the modulo adder, with load/shadow/inc controls.

Test Plan:
- Reset -> all outputs 0, nVRAM_WRITE_REQ=1, BUSY=0; then WR_ADDR 0x7000 -> RD_REQ=1, VRAM_ADDR=0x7000, MSB=0.
- MOD=1, ADDR=0x7000; WR_RW 0x1234; SLOW_ACK after 5 clocks -> nVRAM_WRITE_REQ low exactly 5 clocks, VRAM_WRITE=0x1234, ADDR=0x7001 one clock after ACK, prefetch issued.
- MOD=0x0020, ADDR=0x7FF0, write + ack -> ADDR=0x8010, MSB=1. A subsequent SLOW_ACK is ignored; FAST_ACK with VRAM_HIGH_READ=0xBEEF -> CPU_DATA_OUT=0xBEEF.
- WR_RW 0xAAAA, then WR_RW 0x5555 two clocks later before ACK -> a single write ack, data 0x5555, single increment.
- In WR_PEND, WR_ADDR 0x0100 then ACK -> ADDR=0x0100 (no +MOD), then RD_PEND at 0x0100.
- Assert nRESET low while in WR_PEND -> nVRAM_WRITE_REQ=1, BUSY=0 asynchronously; a late ACK after release causes no state change.

Source files
------------

// File: rtl/lspc_pkg.sv
// rtl/lspc_pkg.sv - shared types and constants for the LSPC VRAM CPU port
package lspc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_PEND = 2'd1,
      INC     = 2'd2,
      RD_PEND = 2'd3
   } lspc_state_e;

   localparam int VRAM_ADDR_W   = 16;
   localparam int FAST_BANK_BIT = 15;

endpackage

// File: rtl/lspc_vram_addr_gen.sv
// rtl/lspc_vram_addr_gen.sv - VRAMADDR/VRAMMOD registers, shadow address and modulo adder
module lspc_vram_addr_gen
   import lspc_pkg::*;
#(
   parameter int                ADDR_W    = VRAM_ADDR_W,
   parameter logic [ADDR_W-1:0] MOD_RESET = '0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              load_i,
   input  logic              shadow_i,
   input  logic              inc_i,
   input  logic              mod_we_i,
   input  logic [ADDR_W-1:0] data_i,
   output logic [ADDR_W-1:0] addr_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] sh_addr_q, sh_addr_d;
   logic              sh_v_q, sh_v_d;
   logic [ADDR_W-1:0] mod_q, mod_d;

   // A direct load always beats a pending shadow or an increment in the same clock.
   always_comb begin
      addr_d    = addr_q;
      sh_addr_d = sh_addr_q;
      sh_v_d    = sh_v_q;
      mod_d     = mod_we_i ? data_i : mod_q;
      if (load_i) begin
         addr_d = data_i;
         sh_v_d = 1'b0;
      end else if (shadow_i) begin
         sh_addr_d = data_i;
         sh_v_d    = 1'b1;
      end else if (inc_i) begin
         if (sh_v_q) begin
            addr_d = sh_addr_q;
            sh_v_d = 1'b0;
         end else begin
            addr_d = addr_q + mod_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         addr_q    <= '0;
         sh_addr_q <= '0;
         sh_v_q    <= 1'b0;
         mod_q     <= MOD_RESET;
      end else begin
         addr_q    <= addr_d;
         sh_addr_q <= sh_addr_d;
         sh_v_q    <= sh_v_d;
         mod_q     <= mod_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/lspc_vram_cpu_port.sv
// rtl/lspc_vram_cpu_port.sv - CPU-side VRAM access port: write requests, auto-increment, read prefetch
module lspc_vram_cpu_port
   import lspc_pkg::*;
#(
   parameter logic [15:0] MOD_RESET = 16'h0000,
   parameter int          ADDR_W    = 16
) (
   input  logic              CLK_24M,
   input  logic              nRESET,
   input  logic              CPU_WR_ADDR,
   input  logic              CPU_WR_RW,
   input  logic              CPU_WR_MOD,
   input  logic              CPU_RD_RW,
   input  logic [15:0]       CPU_DATA_IN,
   output logic [15:0]       CPU_DATA_OUT,
   output logic [ADDR_W-2:0] VRAM_ADDR,
   output logic              REG_VRAMADDR_MSB,
   output logic [15:0]       VRAM_WRITE,
   output logic              nVRAM_WRITE_REQ,
   output logic              RD_REQ,
   input  logic              SLOW_ACK,
   input  logic              FAST_ACK,
   input  logic [15:0]       VRAM_LOW_READ,
   input  logic [15:0]       VRAM_HIGH_READ,
   output logic              BUSY
);

   lspc_state_e state_q, state_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        wq_q, wq_d;
   logic        load, shadow, inc;
   logic [15:0] addr;
   logic        ack;
   logic [15:0] rd_data;

   lspc_vram_addr_gen #(
      .ADDR_W    (ADDR_W),
      .MOD_RESET (MOD_RESET)
   ) u_addr_gen (
      .clk_i    (CLK_24M),
      .rst_n_i  (nRESET),
      .load_i   (load),
      .shadow_i (shadow),
      .inc_i    (inc),
      .mod_we_i (CPU_WR_MOD),
      .data_i   (CPU_DATA_IN),
      .addr_o   (addr)
   );

   // Only the bank selected by the current address may complete an access.
   assign ack     = addr[FAST_BANK_BIT] ? FAST_ACK : SLOW_ACK;
   assign rd_data = addr[FAST_BANK_BIT] ? VRAM_HIGH_READ : VRAM_LOW_READ;

   always_comb begin
      state_d = state_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wq_d    = wq_q;
      load    = 1'b0;
      shadow  = 1'b0;
      inc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (CPU_WR_ADDR) begin
               load    = 1'b1;
               state_d = RD_PEND;
            end else if (CPU_WR_RW) begin
               wdata_d = CPU_DATA_IN;
               state_d = WR_PEND;
            end else if (CPU_RD_RW) begin
               state_d = INC;
            end
         end
         WR_PEND: begin
            if (CPU_WR_ADDR) begin
               shadow = 1'b1;
            end else if (CPU_WR_RW) begin
               wdata_d = CPU_DATA_IN;
            end
            // A write landing with the ack is queued behind the increment.
            if (ack) begin
               state_d = INC;
               wq_d    = CPU_WR_RW && !CPU_WR_ADDR;
            end
         end
         INC: begin
            inc  = 1'b1;
            wq_d = 1'b0;
            if (CPU_WR_ADDR) begin
               load    = 1'b1;
               state_d = RD_PEND;
            end else if (CPU_WR_RW) begin
               wdata_d = CPU_DATA_IN;
               state_d = WR_PEND;
            end else if (wq_q) begin
               state_d = WR_PEND;
            end else begin
               state_d = RD_PEND;
            end
         end
         RD_PEND: begin
            if (CPU_WR_ADDR) begin
               load = 1'b1;
            end else if (CPU_WR_RW) begin
               wdata_d = CPU_DATA_IN;
               state_d = WR_PEND;
            end else if (ack) begin
               rdata_d = rd_data;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= IDLE;
         wdata_q <= '0;
         rdata_q <= '0;
         wq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wq_q    <= wq_d;
      end
   end

   assign VRAM_ADDR        = addr[ADDR_W-2:0];
   assign REG_VRAMADDR_MSB = addr[FAST_BANK_BIT];
   assign VRAM_WRITE       = wdata_q;
   assign CPU_DATA_OUT     = rdata_q;
   assign nVRAM_WRITE_REQ  = (state_q != WR_PEND);
   assign RD_REQ           = (state_q == RD_PEND);
   assign BUSY             = (state_q != IDLE);

endmodule
